// File: rtl/pipe_hazard_unit_if.sv
// Signal bundle between the ID stage (master) and the hazard/forwarding unit (slave).
// The stallCnt/flushCnt counters exist only when HAZ_PERF_EN is defined.
interface pipe_hazard_unit_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);

   logic              idValid;
   logic [REG_AW-1:0] idRsAddr;
   logic [REG_AW-1:0] idRtAddr;
   logic              idUseRs;
   logic              idUseRt;
   logic              idRegWrite;
   logic [REG_AW-1:0] idDstAddr;
   logic              idIsLoad;
   logic              flush;

   logic              pcWrite;
   logic              ifIdWrite;
   logic              stall;
   logic [1:0]        fwdA;
   logic [1:0]        fwdB;
   logic              wbBypRs;
   logic              wbBypRt;

`ifdef HAZ_PERF_EN
   logic [CNT_W-1:0]  stallCnt;
   logic [CNT_W-1:0]  flushCnt;
`endif

   // A zero-width address or counter cannot describe anything useful
   if (REG_AW < 1 || CNT_W < 1) begin : gBadWidth
      $error("pipe_hazard_unit_if: REG_AW and CNT_W must both be at least 1");
   end

   modport master (
      output idValid, idRsAddr, idRtAddr, idUseRs, idUseRt,
      output idRegWrite, idDstAddr, idIsLoad, flush,
      input  pcWrite, ifIdWrite, stall, fwdA, fwdB, wbBypRs, wbBypRt
`ifdef HAZ_PERF_EN
      , input stallCnt, flushCnt
`endif
   );

   modport slave (
      input  idValid, idRsAddr, idRtAddr, idUseRs, idUseRt,
      input  idRegWrite, idDstAddr, idIsLoad, flush,
      output pcWrite, ifIdWrite, stall, fwdA, fwdB, wbBypRs, wbBypRt
`ifdef HAZ_PERF_EN
      , output stallCnt, flushCnt
`endif
   );

endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for a 5-stage pipeline: scoreboard of EX/MEM/WB
// destinations, load-use stall, flush bubbles and registered EX forward selects.
// Optional performance counters are compiled in when HAZ_PERF_EN is defined.
module pipe_hazard_unit #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_unit_if.slave hz
);

   typedef logic [REG_AW-1:0] RegAddr_t;

   typedef struct packed {
      logic     v;
      logic     wr;
      RegAddr_t dst;
      logic     ld;
   } SbEntry_t;

   // With a two-cycle load the value is still not ready while the load sits in MEM
   localparam logic LateLoad = 1'(LOAD_LAT == 2);

   if ((LOAD_LAT != 1 && LOAD_LAT != 2) || CNT_W < 1) begin : gBadParam
      $error("pipe_hazard_unit: LOAD_LAT must be 1 or 2 and CNT_W at least 1");
   end

   SbEntry_t sbEx;
   SbEntry_t sbMem;
   SbEntry_t sbWb;

   logic rsPending;
   logic rtPending;
   logic hazard;
   logic advance;

   function automatic logic regMatch(input RegAddr_t src, input SbEntry_t e);
      return e.v && e.wr && (e.dst == src) && (src != '0);
   endfunction

   function automatic logic loadPending(input RegAddr_t src, input logic srcUsed,
                                        input SbEntry_t ex, input SbEntry_t mem);
      return srcUsed && ((regMatch(src, ex) && ex.ld) ||
                         (LateLoad && regMatch(src, mem) && mem.ld));
   endfunction

   // The newest producer wins, so the EX entry is tested before the MEM entry
   function automatic logic [1:0] fwdSelect(input RegAddr_t src, input logic srcUsed,
                                            input SbEntry_t ex, input SbEntry_t mem);
      logic [1:0] sel;
      sel = 2'b00;
      if (srcUsed) begin
         if (regMatch(src, ex) && !ex.ld) begin
            sel = 2'b10;
         end else if (regMatch(src, mem) && !(mem.ld && LateLoad)) begin
            sel = 2'b01;
         end
      end
      return sel;
   endfunction

   assign rsPending = loadPending(hz.idRsAddr, hz.idUseRs, sbEx, sbMem);
   assign rtPending = loadPending(hz.idRtAddr, hz.idUseRt, sbEx, sbMem);

   assign hazard  = hz.idValid && !hz.flush && (rsPending || rtPending);
   assign advance = hz.idValid && !hz.flush && !hazard;

   assign hz.stall     = hazard;
   assign hz.pcWrite   = !hazard;
   assign hz.ifIdWrite = !hazard;

   assign hz.wbBypRs = hz.idUseRs && regMatch(hz.idRsAddr, sbWb);
   assign hz.wbBypRt = hz.idUseRt && regMatch(hz.idRtAddr, sbWb);

   // Scoreboard shifts every cycle; stalled, flushed or empty ID slots enter EX as bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbEx  <= '0;
         sbMem <= '0;
         sbWb  <= '0;
      end else begin
         sbWb  <= sbMem;
         sbMem <= sbEx;
         if (advance) begin
            sbEx <= '{v: 1'b1, wr: hz.idRegWrite, dst: hz.idDstAddr, ld: hz.idIsLoad};
         end else begin
            sbEx <= '0;
         end
      end
   end

   // Selects are computed from the pre-edge scoreboard so they line up with the instruction now in EX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hz.fwdA <= 2'b00;
         hz.fwdB <= 2'b00;
      end else if (advance) begin
         hz.fwdA <= fwdSelect(hz.idRsAddr, hz.idUseRs, sbEx, sbMem);
         hz.fwdB <= fwdSelect(hz.idRtAddr, hz.idUseRt, sbEx, sbMem);
      end else begin
         hz.fwdA <= 2'b00;
         hz.fwdB <= 2'b00;
      end
   end

`ifdef HAZ_PERF_EN
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   // Both counters stick at all-ones rather than wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hz.stallCnt <= '0;
         hz.flushCnt <= '0;
      end else begin
         if (hazard && (hz.stallCnt != '1)) begin
            hz.stallCnt <= hz.stallCnt + CntOne;
         end
         if (hz.flush && (hz.flushCnt != '1)) begin
            hz.flushCnt <= hz.flushCnt + CntOne;
         end
      end
   end
`endif

endmodule
